// File: rtl/ad_capture_pkg.sv
// Shared types and default sizes for the A/D capture write-side controller.
package ad_capture_pkg;

  localparam int AD_ADDR_W = 10;
  localparam int AD_DATA_W = 16;

  // Capture sequencer states; IDLE encodes as zero so the reset value is IDLE.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRETRIG  = 2'd1,
    ST_POSTTRIG = 2'd2,
    ST_DONE     = 2'd3
  } cap_state_e;

endpackage

// File: rtl/ad_capture_decim2.sv
// Pair accumulator: averages consecutive qualified samples two at a time.
// out_valid is a combinational strobe on the second sample of each pair, so
// the downstream write register issues the write the cycle after that sample.
module ad_capture_decim2
  import ad_capture_pkg::*;
#(
  parameter int DATA_W = AD_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              half_q;
  logic [DATA_W-1:0] first_q;
  logic [DATA_W:0]   pair_sum;

  // Sum at DATA_W+1 bits so 0xFFFF + 0xFFFF cannot overflow before the shift.
  assign pair_sum  = {1'b0, first_q} + {1'b0, in_data};
  assign out_valid = enable && in_valid && half_q;
  assign out_data  = pair_sum[DATA_W:1];

  // Hold the first sample of a pair; clear drops any half pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_q  <= 1'b0;
      first_q <= '0;
    end else if (clear) begin
      half_q  <= 1'b0;
    end else if (enable && in_valid) begin
      if (half_q) begin
        half_q  <= 1'b0;
      end else begin
        half_q  <= 1'b1;
        first_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ad_capture_ctrl.sv
// Write-side controller for the A/D sample buffer (circular pre-trigger
// buffer in ad_ram, programmed post-trigger capture, then freeze).
// Optional build macro AD_CAPTURE_DECIM2_EN: average samples in pairs and
// write one word per pair.
//
// Handshake: sample_valid qualifies sample_data in the same cycle; there is
// no ready, every qualified sample is consumed (or ignored outside capture).
module ad_capture_ctrl
  import ad_capture_pkg::*;
#(
  parameter int ADDR_W = AD_ADDR_W,
  parameter int DATA_W = AD_DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                abort,
  input  logic                trigger,
  input  logic [ADDR_W:0]     post_count,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_data,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic [DATA_W/8-1:0] ram_writebyteenable,
  output logic                busy,
  output logic                done,
  output logic                wrapped,
  output logic [ADDR_W-1:0]   trigger_address,
  output cap_state_e          dbg_state
);

  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  cap_state_e        state_q;
  cap_state_e        state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   post_len_q;
  logic [ADDR_W:0]   post_cnt_q;

  logic              word_valid;
  logic [DATA_W-1:0] word_data;
  logic              wr_en;
  logic              start_capture;
  logic              trig_take;
  logic              capturing;

  assign capturing = (state_q == ST_PRETRIG) || (state_q == ST_POSTTRIG);
  assign dbg_state = state_q;

`ifdef AD_CAPTURE_DECIM2_EN
  ad_capture_decim2 #(
    .DATA_W (DATA_W)
  ) u_decim2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start_capture || abort),
    .enable    (capturing),
    .in_valid  (sample_valid),
    .in_data   (sample_data),
    .out_valid (word_valid),
    .out_data  (word_data)
  );
`else
  assign word_valid = sample_valid;
  assign word_data  = sample_data;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything, including arm.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) state_d = ST_PRETRIG;
        end
        ST_PRETRIG: begin
          // A word written in the trigger cycle is already the first post word.
          if (trigger) begin
            state_d = (word_valid && (post_len_q == CNT_ONE)) ? ST_DONE : ST_POSTTRIG;
          end
        end
        ST_POSTTRIG: begin
          if (word_valid && (post_cnt_q == CNT_ONE)) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Per-cycle control strobes derived from the current state and inputs.
  always_comb begin
    wr_en         = 1'b0;
    start_capture = 1'b0;
    trig_take     = 1'b0;
    if (!abort) begin
      case (state_q)
        ST_IDLE, ST_DONE: start_capture = arm;
        ST_PRETRIG: begin
          wr_en     = word_valid;
          trig_take = trigger;
        end
        ST_POSTTRIG: wr_en = word_valid;
        default: ;
      endcase
    end
  end

  // Write pointer, post counter, trigger address and registered RAM port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q            <= '0;
      post_len_q          <= '0;
      post_cnt_q          <= '0;
      wrapped             <= 1'b0;
      trigger_address     <= '0;
      ram_address         <= '0;
      ram_writedata       <= '0;
      ram_writebyteenable <= '0;
    end else begin
      ram_writebyteenable <= wr_en ? '1 : '0;
      if (wr_en) begin
        ram_address   <= wr_ptr_q;
        ram_writedata <= word_data;
        wr_ptr_q      <= wr_ptr_q + PTR_ONE;
        if (&wr_ptr_q) wrapped <= 1'b1;
      end
      if (start_capture) begin
        wr_ptr_q        <= '0;
        wrapped         <= 1'b0;
        trigger_address <= '0;
        post_len_q      <= (post_count == '0) ? CNT_ONE : post_count;
      end
      if (trig_take) begin
        trigger_address <= wr_ptr_q;
        post_cnt_q      <= wr_en ? (post_len_q - CNT_ONE) : post_len_q;
      end else if ((state_q == ST_POSTTRIG) && wr_en) begin
        post_cnt_q <= post_cnt_q - CNT_ONE;
      end
    end
  end

  // Status flags registered from the next state so they track the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == ST_PRETRIG) || (state_d == ST_POSTTRIG);
      done <= (state_d == ST_DONE);
    end
  end

endmodule
